// File: rtl/sdram_test_pkg.sv
// Shared types and constants for the SDRAM stress-test blocks (arbiter, port testers).
package sdram_test_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int ADDRW_DEF = 22;
  localparam int DATAW_DEF = 16;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_select.sv
// Round-robin pick: first set req bit searched upward from last+1, wrapping modulo N.
// Purely combinational, zero latency; no flow control of its own.
module rr_select
  import sdram_test_pkg::*;
#(
  parameter  int N  = 5,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] shifted;
  logic [N-1:0]   rot;

  always_comb begin
    dbl       = {req, req};
    shifted   = dbl >> (int'(last) + 1);
    rot       = shifted[N-1:0];
    any       = |req;
    grant_idx = '0;
    // Descending scan so the lowest rotated position wins, then map back to a port index.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) grant_idx = IW'((int'(last) + 1 + k) % N);
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port among NPORTS requesters, round-robin, one word at a time.
// dn_req one cycle after up_req; up_ack one cycle after dn_ack (or watchdog expiry); requesters wait by holding up_req.
module sdram_port_arbiter
  import sdram_test_pkg::*;
#(
  parameter  int NPORTS  = 5,
  parameter  int ADDRW   = ADDRW_DEF,
  parameter  int DATAW   = DATAW_DEF,
  parameter  int TIMEOUT = 255,
  localparam int IW      = idx_w(NPORTS),
  localparam int TW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NPORTS-1:0]       up_req,
  input  logic [NPORTS-1:0]       up_we,
  input  logic [NPORTS*ADDRW-1:0] up_addr,
  input  logic [NPORTS*DATAW-1:0] up_wdata,
  output logic [NPORTS-1:0]       up_ack,
  output logic                    up_err,
  output logic [DATAW-1:0]        up_rdata,
  output logic                    dn_req,
  output logic                    dn_we,
  output logic [ADDRW-1:0]        dn_addr,
  output logic [DATAW-1:0]        dn_wdata,
  input  logic                    dn_ack,
  input  logic [DATAW-1:0]        dn_rdata,
  output logic                    busy,
  output logic [IW-1:0]           last_grant,
  output logic                    timeout_pulse
);

  localparam logic [TW-1:0]     TLIM = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [NPORTS-1:0] ONE  = NPORTS'(1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic [IW-1:0] sel;
  logic          sel_any;
  logic          expire;

  rr_select #(.N(NPORTS)) u_sel (
    .req       (up_req),
    .last      (last_grant),
    .grant_idx (sel),
    .any       (sel_any)
  );

  assign expire = (TIMEOUT != 0) && (timer == TLIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      idx           <= '0;
      timer         <= '0;
      busy          <= 1'b0;
      dn_req        <= 1'b0;
      dn_we         <= 1'b0;
      dn_addr       <= '0;
      dn_wdata      <= '0;
      up_ack        <= '0;
      up_err        <= 1'b0;
      up_rdata      <= '0;
      timeout_pulse <= 1'b0;
      last_grant    <= IW'(NPORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            idx      <= sel;
            dn_req   <= 1'b1;
            dn_we    <= up_we[sel];
            dn_addr  <= up_addr[sel*ADDRW +: ADDRW];
            dn_wdata <= up_wdata[sel*DATAW +: DATAW];
            timer    <= '0;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // A real ack beats a simultaneous watchdog expiry.
          if (dn_ack) begin
            dn_req     <= 1'b0;
            up_rdata   <= dn_rdata;
            up_ack     <= ONE << idx;
            up_err     <= 1'b0;
            last_grant <= idx;
            state      <= DONE;
          end else if (expire) begin
            dn_req        <= 1'b0;
            up_rdata      <= '0;
            up_ack        <= ONE << idx;
            up_err        <= 1'b1;
            timeout_pulse <= 1'b1;
            last_grant    <= idx;
            state         <= DONE;
          end
        end
        DONE: begin
          // One-cycle holdoff so a requester dropping up_req on its ack is not re-granted.
          up_ack        <= '0;
          up_err        <= 1'b0;
          timeout_pulse <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomised scoreboard bench for sdram_port_arbiter (NPORTS=5, TIMEOUT=8).
module tb_sdram_port_arbiter;

  localparam int N  = 5;
  localparam int AW = 22;
  localparam int DW = 16;
  localparam int T  = 8;
  localparam int IW = $clog2(N);

  localparam int S_IDLE = 0;
  localparam int S_WAIT = 1;
  localparam int S_DONE = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    up_req;
  logic [N-1:0]    up_we;
  logic [N*AW-1:0] up_addr;
  logic [N*DW-1:0] up_wdata;
  logic [N-1:0]    up_ack;
  logic            up_err;
  logic [DW-1:0]   up_rdata;
  logic            dn_req;
  logic            dn_we;
  logic [AW-1:0]   dn_addr;
  logic [DW-1:0]   dn_wdata;
  logic            dn_ack;
  logic [DW-1:0]   dn_rdata;
  logic            busy;
  logic [IW-1:0]   last_grant;
  logic            timeout_pulse;

  sdram_port_arbiter #(.NPORTS(N), .ADDRW(AW), .DATAW(DW), .TIMEOUT(T)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .up_req        (up_req),
    .up_we         (up_we),
    .up_addr       (up_addr),
    .up_wdata      (up_wdata),
    .up_ack        (up_ack),
    .up_err        (up_err),
    .up_rdata      (up_rdata),
    .dn_req        (dn_req),
    .dn_we         (dn_we),
    .dn_addr       (dn_addr),
    .dn_wdata      (dn_wdata),
    .dn_ack        (dn_ack),
    .dn_rdata      (dn_rdata),
    .busy          (busy),
    .last_grant    (last_grant),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            due;
  } exp_t;

  exp_t          expq[$];
  int            total = 0;
  int            bad = 0;
  int            lat_mode;
  bit            force_en;
  logic [DW-1:0] force_rd;
  bit            stray_en;
  bit            done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Downstream controller model: chooses a latency per transaction and records the expected reply.
  initial begin : responder
    int            lat;
    int            cnt;
    bit            active;
    bit            prev;
    logic [DW-1:0] val;
    exp_t          e;
    active = 0; prev = 0; cnt = 0; lat = 1; val = '0;
    dn_ack = 1'b0; dn_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        active = 0;
        prev   = 0;
        dn_ack = 1'b0;
      end else begin
        if (dn_req && !prev) begin
          lat     = (lat_mode == 0) ? int'($urandom_range(1, T + 1)) : lat_mode;
          val     = force_en ? force_rd : DW'($urandom);
          e.err   = (lat > T);
          e.rdata = (lat > T) ? '0 : val;
          e.due   = cyc + ((lat > T) ? T : lat);
          expq.push_back(e);
          active  = 1;
          cnt     = 0;
        end
        prev = dn_req;
        @(negedge clk);
        dn_ack = 1'b0;
        if (!reset_n) begin
          active = 0;
        end else if (active) begin
          cnt++;
          if (cnt == lat) begin
            dn_ack   = 1'b1;
            dn_rdata = val;
            active   = 0;
          end
        end else if (stray_en && !dn_req && $urandom_range(0, 3) == 0) begin
          dn_ack   = 1'b1;
          dn_rdata = DW'($urandom);
        end
      end
    end
  end

  // Monitor: protocol-level model of the arbiter, pops expected replies on every up_ack.
  initial begin : monitor
    int            m_last;
    int            m_st;
    int            m_port;
    int            gw;
    bit            found;
    logic [AW-1:0] h_addr;
    logic          h_we;
    logic [DW-1:0] h_wdata;
    logic [N-1:0]  oh;
    exp_t          e;
    m_last = N - 1; m_st = S_IDLE; m_port = 0; gw = 0; found = 0;
    h_addr = '0; h_we = 1'b0; h_wdata = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      #1;
      if (done) begin
        chk("no_pending_txn", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      if (!reset_n) begin
        chk("rst_dn_req", 32'(dn_req), 32'd0);
        chk("rst_up_ack", 32'(up_ack), 32'd0);
        chk("rst_up_err", 32'(up_err), 32'd0);
        chk("rst_up_rdata", 32'(up_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
        chk("rst_last_grant", 32'(last_grant), 32'(N - 1));
        m_last = N - 1;
        m_st   = S_IDLE;
        expq.delete();
      end else begin
        case (m_st)
          S_IDLE: begin
            found = 0;
            gw    = 0;
            for (int k = 1; k <= N; k++) begin
              if (!found && up_req[(m_last + k) % N]) begin
                gw    = (m_last + k) % N;
                found = 1;
              end
            end
            chk("grant_issued", 32'(dn_req), 32'(found));
            chk("idle_no_ack", 32'(up_ack), 32'd0);
            if (dn_req) begin
              if (found) begin
                chk("dn_addr", 32'(dn_addr), 32'(up_addr[gw*AW +: AW]));
                chk("dn_we", 32'(dn_we), 32'(up_we[gw]));
                chk("dn_wdata", 32'(dn_wdata), 32'(up_wdata[gw*DW +: DW]));
              end
              h_addr  = dn_addr;
              h_we    = dn_we;
              h_wdata = dn_wdata;
              m_port  = gw;
              m_last  = gw;
              m_st    = S_WAIT;
            end
          end
          S_WAIT: begin
            if (up_ack != '0) begin
              if (expq.size() == 0) begin
                bad++;
                total++;
                $display("FAIL ack_unexpected: actual=%0h required=none (cycle %0d)", up_ack, cyc);
              end else begin
                e  = expq.pop_front();
                oh = '0;
                oh[m_port] = 1'b1;
                chk("ack_port", 32'(up_ack), 32'(oh));
                chk("ack_err", 32'(up_err), 32'(e.err));
                chk("ack_rdata", 32'(up_rdata), 32'(e.rdata));
                chk("ack_timeout_pulse", 32'(timeout_pulse), 32'(e.err));
                chk("ack_cycle", 32'(cyc), 32'(e.due));
                chk("ack_last_grant", 32'(last_grant), 32'(m_port));
                chk("ack_dn_req_low", 32'(dn_req), 32'd0);
              end
              m_st = S_DONE;
            end else begin
              chk("wait_dn_req", 32'(dn_req), 32'd1);
              chk("wait_addr_stable", 32'(dn_addr), 32'(h_addr));
              chk("wait_we_stable", 32'(dn_we), 32'(h_we));
              chk("wait_wdata_stable", 32'(dn_wdata), 32'(h_wdata));
              chk("wait_timeout_pulse", 32'(timeout_pulse), 32'd0);
              if (expq.size() > 0 && cyc >= expq[0].due) begin
                bad++;
                total++;
                $display("FAIL ack_missing: actual=no ack at cycle %0d required=ack at cycle %0d", cyc, expq[0].due);
                void'(expq.pop_front());
                m_st = S_DONE;
              end
            end
          end
          default: begin
            chk("done_ack_clear", 32'(up_ack), 32'd0);
            chk("done_err_clear", 32'(up_err), 32'd0);
            chk("done_tmo_clear", 32'(timeout_pulse), 32'd0);
            chk("done_no_regrant", 32'(dn_req), 32'd0);
            m_st = S_IDLE;
          end
        endcase
        chk("busy", 32'(busy), 32'(m_st != S_IDLE));
      end
    end
  end

  task automatic raise(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    up_we[i]              = we;
    up_addr[i*AW +: AW]   = a;
    up_wdata[i*DW +: DW]  = d;
    up_req[i]             = 1'b1;
  endtask

  // Requesters drop up_req when they see their ack; masked ones re-request with probability pct%.
  task automatic drive(input int cycles, input logic [N-1:0] mask, input int pct);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (up_ack[i]) up_req[i] = 1'b0;
        else if (!up_req[i] && mask[i] && $urandom_range(0, 99) < pct)
          raise(i, 1'($urandom), AW'($urandom), DW'($urandom));
      end
    end
  endtask

  initial begin : stimulus
    reset_n = 1'b0;
    up_req = '0; up_we = '0; up_addr = '0; up_wdata = '0;
    lat_mode = 1; force_en = 0; force_rd = '0; stray_en = 0; done = 0;

    // All ports requesting through reset: port 0 first, then 1,2,3,4,0.
    for (int i = 0; i < N; i++) raise(i, 1'b0, AW'(32'h100 * (i + 1)), DW'(32'hA000 + i));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drive(20, '1, 100);
    drive(20, '0, 0);

    // Port 2 reads 0x1234, controller answers 0xBEEF after 4 cycles.
    force_en = 1; force_rd = 16'hBEEF; lat_mode = 4;
    raise(2, 1'b0, 22'h1234, 16'h0);
    drive(12, '0, 0);
    force_en = 0;

    // Controller never answers in time; its late ack lands as a stray.
    lat_mode = T + 1; stray_en = 1;
    raise(1, 1'b1, AW'($urandom), DW'($urandom));
    drive(16, '0, 0);

    // Ack on the same edge the watchdog expires.
    lat_mode = T;
    raise(4, 1'b0, AW'($urandom), DW'($urandom));
    drive(14, '0, 0);

    // Requester withdraws while in WAIT; ack still delivered.
    lat_mode = 5;
    raise(3, 1'b0, AW'($urandom), DW'($urandom));
    @(negedge clk);
    up_req[3] = 1'b0;
    drive(12, '0, 0);

    // Reset during WAIT; afterwards port 0 must win.
    lat_mode = 6;
    raise(2, 1'b0, AW'($urandom), DW'($urandom));
    raise(3, 1'b1, AW'($urandom), DW'($urandom));
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    for (int i = 0; i < N; i++) raise(i, 1'($urandom), AW'($urandom), DW'($urandom));
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    lat_mode = 1;
    drive(20, '1, 100);
    drive(20, '0, 0);

    // Random traffic with random latencies including expiry and strays.
    lat_mode = 0;
    drive(400, '1, 30);
    drive(80, '0, 0);

    // Single requester back-to-back with 1-cycle controller.
    lat_mode = 1; stray_en = 0;
    drive(18, 5'b01000, 100);
    drive(12, '0, 0);

    done = 1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Round-robin arbiter that shares one SDRAM controller port between `NPORTS` stress-test requesters, such as port testers, on the same `clk`. It serialises single-word transactions, forwards one at a time downstream, and returns read data and a one-cycle ack to the winning requester. A per-transaction watchdog aborts stalled transactions so that a hung controller is reported as an error rather than freezing the test.

## Interface
Parameters:
- `NPORTS`, 5, number of requesters (2..8)
- `ADDRW`, 22, word address width
- `DATAW`, 16, data width
- `TIMEOUT`, 255, maximum cycles in WAIT before abort; 0 disables the watchdog

Ports:
- `clk`  in  1  system clock; the only clock
- `reset_n`  in  1  reset, asynchronous and active-low
- `up_req`  in  NPORTS  per-requester level request; held until that requester's ack
- `up_we`  in  NPORTS  per-requester write enable
- `up_addr`  in  NPORTS*ADDRW  flattened addresses; requester i occupies `[i*ADDRW +: ADDRW]`
- `up_wdata`  in  NPORTS*DATAW  flattened write data, same packing as `up_addr`
- `up_ack`  out  NPORTS  one-hot, one-cycle completion pulse
- `up_err`  out  1  qualifies `up_ack`: the transaction timed out
- `up_rdata`  out  DATAW  shared read data; valid in the `up_ack` cycle
- `dn_req`  out  1  downstream level request
- `dn_we`  out  1  downstream write enable
- `dn_addr`  out  ADDRW  downstream address
- `dn_wdata`  out  DATAW  downstream write data
- `dn_ack`  in  1  downstream one-cycle completion pulse
- `dn_rdata`  in  DATAW  downstream read data; valid with `dn_ack`
- `busy`  out  1  high whenever the state is not IDLE
- `last_grant`  out  $clog2(NPORTS)  index of the most recently completed requester
- `timeout_pulse`  out  1  one-cycle pulse when a transaction is aborted

## Operation
- States are IDLE, WAIT and DONE. All outputs are registered.
- **IDLE**
  - If any `up_req` bit is high, the winner is the first requesting index searched upward from `last_grant+1`, wrapping modulo NPORTS.
  - On that edge the arbiter latches the winner's index, `we`, `addr` and `wdata` into `dn_*`, sets `dn_req` to 1, clears the timer and enters WAIT.
- **WAIT**
  - `dn_req` and all `dn_*` fields are held stable.
  - The timer increments every cycle; its width is $clog2(TIMEOUT+1), minimum 1.
  - If `dn_ack` is high: `dn_req`←0, `up_rdata`←`dn_rdata`, `up_ack[idx]`←1, `up_err`←0, `last_grant`←idx, next state DONE.
  - Else if TIMEOUT≠0 and timer==TIMEOUT-1: `dn_req`←0, `up_rdata`←0, `up_ack[idx]`←1, `up_err`←1, `timeout_pulse`←1, `last_grant`←idx, next state DONE.
- **DONE**
  - Lasts exactly one cycle, during which the ack is visible. It then clears `up_ack`, `up_err` and `timeout_pulse` and returns to IDLE.
  - This holdoff exists so that a requester which drops `up_req` on the edge where it sees its ack is not re-granted.
- **Write transactions:** `up_rdata` is loaded from `dn_rdata` anyway; requesters ignore it.
- **Boundary rules**
  - `dn_ack` in IDLE or DONE is a stray pulse: it is ignored and causes no state change.
  - `dn_ack` on the same edge the timer expires: the ack wins and `up_err` stays 0.
  - Only one requester active: it may be re-granted on every IDLE visit.
  - `last_grant` wraps from NPORTS-1 to 0.
  - A requester dropping `up_req` while in WAIT does not cancel the transaction; the ack is still delivered.
  - Assertion of `reset_n` in any state takes effect immediately and asynchronously: the state goes to IDLE, every output goes to 0, and `last_grant` goes to NPORTS-1 so that port 0 has first priority. Any in-flight downstream transaction is abandoned.

## Timing
- If `up_req[i]` is high before edge E0 (arbiter in IDLE), `dn_req` is high after E0.
- If `dn_ack` is high before edge E1, `up_ack[i]` and `up_rdata` are valid for the single cycle after E1. The arbiter is back in IDLE after E1+1 and can issue again at E1+2.
- The minimum period is 3 cycles per transaction when `dn_ack` returns one cycle after `dn_req`.
- On timeout, `up_ack` rises TIMEOUT cycles after `dn_req` rose.
- No combinational path exists from any input to any output.

## Structure
- The shared package `sdram_test_pkg` holds:
  - the state enum {IDLE, WAIT, DONE};
  - the function `idx_w(n)=$clog2(n)`;
  - the default ADDRW and DATAW constants, which are shared with the port testers.
- One sub-module, `rr_select`, is combinational: inputs are `req` and `last`, outputs are `grant_idx` and `any`. It implements the rotate, priority-encode and un-rotate steps, and is reusable elsewhere.

## Test plan
- Reset values: all five `up_req` high at reset release → port 0 is granted first, then grants proceed in order 1,2,3,4,0. `last_grant` reads 4 during reset.
- Read data return: port 2 reads address 0x1234 and the model returns 0xBEEF after 4 cycles → `dn_addr`=0x1234 and `dn_we`=0. `up_ack`=5'b00100 and `up_rdata`=0xBEEF, both for exactly one cycle; `up_err`=0.
- Timeout: TIMEOUT=8 and the model never acks → `up_ack` and `up_err` assert 8 cycles after `dn_req` rose, with `timeout_pulse` one cycle wide and `up_rdata`=0. A later stray `dn_ack` is ignored.
- Simultaneous ack and expiry: `dn_ack` arrives on the cycle the timer expires → normal ack with `up_err`=0 and no `timeout_pulse`.
- Reset mid-transaction: `reset_n` is pulsed low during WAIT → `dn_req` drops immediately, no `up_ack` is produced, and the next grant goes to port 0.
- Back-to-back requests: a single requester holds `up_req` continuously with a 1-cycle ack model → 3-cycle grant period and exactly one `up_ack` per `dn_req`.
